// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: the buffered {pc, instr}
// entry, the fetch PC step, and a helper for sizing occupancy counters.
package fetch_pkg;

    localparam int FETCH_PC_W    = 9;
    localparam int FETCH_INSTR_W = 32;

    // Canonical no-op encoding (addi x0, x0, 0).
    localparam logic [FETCH_INSTR_W-1:0] NOP = 32'h00000013;

    // Byte distance between consecutive instruction words.
    localparam logic [FETCH_PC_W-1:0] PC_STEP = FETCH_PC_W'(4);

    typedef struct packed {
        logic [FETCH_PC_W-1:0]    pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Bits needed to count 0..depth entries inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries. Flush wins over push so that a
// response arriving in the same cycle as a redirect never survives it.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  fetch_entry_t                push_data,
    input  logic                        pop,
    output fetch_entry_t                head,
    output logic [cnt_width(DEPTH)-1:0] cnt
);

    localparam int CNT_W = cnt_width(DEPTH);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A pop on an empty FIFO is ignored rather than corrupting the count.
    assign do_pop = pop & (cnt != '0);

    // Entry storage write.
    // NOTE: storage has no reset; pointers and count define what is valid,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Head presentation; zero while empty so idle outputs are clean.
    // NOTE: head gets a default before the condition, so no latch is inferred.
    always_comb begin
        head = '0;
        if (cnt != '0) begin
            head = mem[rd_ptr];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the fetch PC, issues one-word reads to a single-cycle
// BRAM, tracks the single in-flight request and hands responses to the
// output FIFO. Redirects discard all wrong-path state.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = FETCH_PC_W,
    parameter int              INSTR_W  = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    cache_pc,
    output logic               cache_en,
    input  logic [INSTR_W-1:0] cache_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int CNT_W = cnt_width(DEPTH);

    logic [PC_W-1:0]  pc_q;
    logic             inf_q;
    logic [PC_W-1:0]  inf_pc_q;
    logic [CNT_W-1:0] cnt;
    logic             pop;
    logic [CNT_W:0]   occupancy;
    fetch_entry_t     push_data;
    fetch_entry_t     head;
    logic             unused_redirect_lsbs;

    // The target is forced word-aligned; its low bits carry no information.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign pop = out_valid & out_ready;

    // Entries that will be held after this cycle if nothing new is issued:
    // current FIFO contents plus the response already on its way, minus the
    // entry leaving now. A new request is only allowed if it has a slot.
    assign occupancy = {1'b0, cnt} + (CNT_W + 1)'(inf_q) - (CNT_W + 1)'(pop);

    assign cache_en = rst & ~redirect_valid & (occupancy < (CNT_W + 1)'(DEPTH));
    assign cache_pc = pc_q;

    // PC and in-flight tracking; redirect overrides any issue.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            inf_q    <= 1'b0;
            inf_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q  <= {redirect_pc[PC_W-1:2], 2'b00};
            inf_q <= 1'b0;
        end else if (cache_en) begin
            pc_q     <= pc_q + PC_STEP;
            inf_q    <= 1'b1;
            inf_pc_q <= pc_q;
        end else begin
            inf_q <= 1'b0;
        end
    end

    // The BRAM answers one cycle after the request, so the response pairs
    // with the PC captured at issue time.
    assign push_data = '{pc: inf_pc_q, instr: cache_instr};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (inf_q),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .cnt       (cnt)
    );

    assign out_valid = (cnt != '0);
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming with backpressure,
// redirects (aligned, unaligned, across the wrap) and mid-run reset.
module tb_fetch_unit;

    localparam int PC_W    = 9;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [PC_W-1:0]    cache_pc;
    logic               cache_en;
    logic [INSTR_W-1:0] cache_instr = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;

    logic [INSTR_W-1:0] mem [128];
    int total = 0;
    int bad   = 0;
    logic [PC_W-1:0] exp_pc;

    fetch_unit #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (9'h000),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cache_pc       (cache_pc),
        .cache_en       (cache_en),
        .cache_instr    (cache_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Single-cycle-latency instruction memory with memory[i] = i.
    always @(posedge clk) begin
        if (cache_en) cache_instr <= mem[cache_pc[8:2]];
    end

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        tick(); tick();
        #1;
        total++; if (cache_en !== 1'b0) begin bad++; $display("FAIL reset_cache_en: got %0b want 0", cache_en); end
        total++; if (cache_pc !== 9'h000) begin bad++; $display("FAIL reset_cache_pc: got %h want 000", cache_pc); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        total++; if (out_pc !== 9'h000) begin bad++; $display("FAIL reset_out_pc: got %h want 000", out_pc); end
        total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
        tick();
    endtask

    // Free run from reset, then out_ready low in cycles 3..7.
    task automatic test_stream_and_hold();
        rst = 1'b1;
        exp_pc = 9'h000;
        for (int c = 0; c < 16; c++) begin
            out_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
            #1;
            if (c == 0) begin
                total++; if (cache_en !== 1'b1) begin bad++; $display("FAIL first_issue_en: got %0b want 1", cache_en); end
                total++; if (cache_pc !== 9'h000) begin bad++; $display("FAIL first_issue_pc: got %h want 000", cache_pc); end
            end
            if (c < 2) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid c%0d: got %0b want 0", c, out_valid); end
            end
            if (c == 2) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL first_valid c2: got %0b want 1", out_valid); end
            end
            if (c >= 4 && c <= 7) begin
                total++; if (cache_en !== 1'b0) begin bad++; $display("FAIL hold_cache_en c%0d: got %0b want 0", c, cache_en); end
            end
            if (c >= 3 && c <= 7) begin
                total++; if (out_valid !== 1'b1 || out_pc !== 9'h004) begin
                    bad++; $display("FAIL hold_head c%0d: got valid=%0b pc=%h want valid=1 pc=004", c, out_valid, out_pc);
                end
            end
            if (out_valid && out_ready) begin
                total++; if (out_pc !== exp_pc || out_instr !== 32'(exp_pc >> 2)) begin
                    bad++; $display("FAIL stream c%0d: got pc=%h instr=%h want pc=%h instr=%h",
                                    c, out_pc, out_instr, exp_pc, 32'(exp_pc >> 2));
                end
                exp_pc = exp_pc + 9'd4;
            end
            tick();
        end
        // Pops expected in cycle 2 and cycles 8..15: nine entries in total.
        total++; if (exp_pc !== 9'd36) begin bad++; $display("FAIL stream_count: got next_pc=%h want 024", exp_pc); end
    endtask

    // Redirect while one entry is buffered and one request is in flight.
    task automatic test_redirect_full();
        redirect_valid = 1'b1; redirect_pc = 9'h100; out_ready = 1'b0;
        #1;
        total++; if (cache_en !== 1'b0) begin bad++; $display("FAIL redir_cycle_en: got %0b want 0", cache_en); end
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_r1_valid: got %0b want 0", out_valid); end
        total++; if (cache_en !== 1'b1 || cache_pc !== 9'h100) begin
            bad++; $display("FAIL redir_r1_issue: got en=%0b pc=%h want en=1 pc=100", cache_en, cache_pc);
        end
        tick(); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_r2_valid: got %0b want 0", out_valid); end
        tick(); #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h100 || out_instr !== 32'h40) begin
            bad++; $display("FAIL redir_r3_head: got v=%0b pc=%h instr=%h want v=1 pc=100 instr=40", out_valid, out_pc, out_instr);
        end
        tick(); #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h104 || out_instr !== 32'h41) begin
            bad++; $display("FAIL redir_r4_head: got v=%0b pc=%h instr=%h want v=1 pc=104 instr=41", out_valid, out_pc, out_instr);
        end
        tick();
    endtask

    task automatic test_redirect_unaligned();
        redirect_valid = 1'b1; redirect_pc = 9'h102;
        tick();
        redirect_valid = 1'b0;
        #1;
        total++; if (cache_en !== 1'b1 || cache_pc !== 9'h100) begin
            bad++; $display("FAIL unaligned_issue: got en=%0b pc=%h want en=1 pc=100", cache_en, cache_pc);
        end
        tick(); tick(); #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h100 || out_instr !== 32'h40) begin
            bad++; $display("FAIL unaligned_head: got v=%0b pc=%h instr=%h want v=1 pc=100 instr=40", out_valid, out_pc, out_instr);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] wrap_pcs [4];
        wrap_pcs = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
        redirect_valid = 1'b1; redirect_pc = 9'h1F8;
        tick();
        redirect_valid = 1'b0;
        tick(); tick();
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (out_valid !== 1'b1 || out_pc !== wrap_pcs[k] || out_instr !== 32'(wrap_pcs[k] >> 2)) begin
                bad++; $display("FAIL wrap_%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                                k, out_valid, out_pc, out_instr, wrap_pcs[k], 32'(wrap_pcs[k] >> 2));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        #1;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid: got %0b want 1", out_valid); end
        rst = 1'b0;
        #1;
        total++; if (cache_en !== 1'b0) begin bad++; $display("FAIL midrst_en: got %0b want 0", cache_en); end
        tick(); #1;
        total++; if (out_valid !== 1'b0 || cache_pc !== 9'h000 || out_pc !== 9'h000 || out_instr !== 32'h0) begin
            bad++; $display("FAIL midrst_state: got v=%0b cpc=%h opc=%h instr=%h want v=0 cpc=000 opc=000 instr=0",
                            out_valid, cache_pc, out_pc, out_instr);
        end
        tick();
        rst = 1'b1;
        #1;
        total++; if (cache_en !== 1'b1 || cache_pc !== 9'h000) begin
            bad++; $display("FAIL midrst_restart: got en=%0b pc=%h want en=1 pc=000", cache_en, cache_pc);
        end
        tick(); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_c1_valid: got %0b want 0", out_valid); end
        tick(); #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h000 || out_instr !== 32'h0) begin
            bad++; $display("FAIL midrst_c2_head: got v=%0b pc=%h instr=%h want v=1 pc=000 instr=0", out_valid, out_pc, out_instr);
        end
        tick(); #1;
        total++; if (out_valid !== 1'b1 || out_pc !== 9'h004 || out_instr !== 32'h1) begin
            bad++; $display("FAIL midrst_c3_head: got v=%0b pc=%h instr=%h want v=1 pc=004 instr=1", out_valid, out_pc, out_instr);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'(i);
        test_reset();
        test_stream_and_hold();
        test_redirect_full();
        test_redirect_unaligned();
        test_wrap();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Front-end fetch stage of the OoO core. Holds the architectural fetch PC and issues one-word reads to the single-cycle-latency instruction BRAM. Buffers returned instructions in a small FIFO and presents {pc, instr} to the fetch→decode skid buffer over a valid/ready handshake. Accepts redirects from the branch/flush logic, discarding all wrong-path state.

## Interface
- PC_W, 9, fetch PC width in bits; byte address, word-aligned.
- INSTR_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- DEPTH, 2, output FIFO entries (≥2).
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- cache_pc  out  PC_W  BRAM read address (byte PC; memory indexes pc[PC_W-1:2]).
- cache_en  out  1  BRAM read enable; a request is issued on every cycle this is high.
- cache_instr  in  INSTR_W  BRAM data, valid the cycle after the request.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream skid buffer can accept.
- out_pc  out  PC_W  PC of head entry.
- out_instr  out  INSTR_W  instruction of head entry.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  PC_W  restart target (bits [1:0] ignored, treated as 0).

## Operation
- State: pc_q; in-flight flag inf_q with inf_pc_q; FIFO of {pc, instr}, occupancy cnt.
- Issue rule: cache_en = rst & ~redirect_valid & ((cnt + inf_q − pop) < DEPTH), where pop = out_valid & out_ready. cache_pc = pc_q. On issue: pc_q ← pc_q + 4 (mod 2^PC_W), inf_q ← 1, inf_pc_q ← pc_q. Otherwise inf_q ← 0.
- Response: when inf_q = 1, push {inf_pc_q, cache_instr} into the FIFO. The issue rule guarantees the FIFO never overflows.
- Output: out_valid = (cnt ≠ 0); out_pc and out_instr come from the FIFO head. Holding rule: head data and valid stay stable while out_valid & ~out_ready.
- Redirect (highest priority):
  - FIFO is cleared (cnt ← 0), inf_q ← 0, and any response arriving next cycle is dropped.
  - pc_q ← {redirect_pc[PC_W-1:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - A pop coinciding with redirect counts as transferred. Downstream flushes on the same redirect_valid.
- Wrap-around: PC 0x1FC + 4 → 0x000 with no special handling. The bench detects program end on this wrap.

## Timing
- Reset (rst = 0): pc_q = RESET_PC, inf_q = 0, cnt = 0. Outputs: cache_en = 0, cache_pc = RESET_PC, out_valid = 0, out_pc = 0, out_instr = 0.
- First cycle with rst = 1 (cycle 0): request at RESET_PC. Data cycle 1, pushed at end of cycle 1, out_valid in cycle 2.
- Request-to-out_valid latency: 2 cycles. Sustained throughput with out_ready = 1: 1 instr/cycle at DEPTH = 2.
- out_ready low: at most DEPTH entries are buffered (one may still be in flight when ready drops). Issue stops and pc_q holds.
- Redirect in cycle r: request at the target in cycle r+1, out_valid in cycle r+3. out_valid = 0 in cycles r+1 and r+2.
- Reset asserted mid-operation: all state returns to reset values the next edge. An in-flight response is dropped.

## Structure
- Shared package fetch_pkg holds:
  - the fetch_entry_t struct {pc, instr};
  - NOP = 32'h00000013;
  - the PC step constant 4.
- One sub-module, fetch_fifo: parameterized DEPTH FIFO of fetch_entry_t with push, pop, flush and cnt. Flush takes priority over push.
- fetch_unit contains the PC, in-flight tracking and issue logic only.

## Test plan
- Reset then free-run with memory[i] = i, out_ready = 1 → out_valid first in cycle 2, pcs 0x000, 0x004, 0x008…, instr 0, 1, 2…, one per cycle.
- Hold out_ready = 0 from cycle 3 for 5 cycles → cache_en deasserts, out_pc stays 0x004, no entry lost or duplicated after release.
- Redirect to 0x100 while FIFO is full and a request is in flight → no stale pc emitted; next out_pc = 0x100, first valid 3 cycles after redirect.
- Redirect with pc 0x102 → fetch restarts at 0x100.
- Run past 0x1FC → out_pc sequence 0x1F8, 0x1FC, 0x000, 0x004.
- Reset asserted while out_valid = 1 and in-flight → next cycle out_valid = 0, cache_pc = RESET_PC; after release the sequence restarts from RESET_PC.
